fft_output_pingpong: RTL

- Double-buffered (ping-pong) FFT result packer. It accepts one SAMPLE_W-bit FFT output sample per cycle over a valid/ready stream and stores a full frame of SAMPLES samples in one bank.
- When the frame is complete, it hands that bank to the read side. The read side emits LINE_W-bit lines over a valid/ready stream toward the host/DMA, while the other bank fills.
- Adds what a single-buffer index-addressed store lacks: automatic write addressing, optional bit-reversed reordering, backpressure on both sides, and flush.

---
 rtl/fft_out_pkg.sv | 24 ++
 rtl/fft_bank_ram.sv | 31 +++
 rtl/fft_output_pingpong.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fft_out_pkg.sv
// Shared sizing for the FFT output ping-pong packer: default geometry, derived
// line/address widths for that geometry, and the index bit-reversal helper.
package fft_out_pkg;

    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_SAMPLES  = 2048;
    localparam int DEF_LINE_W   = 512;

    localparam int DEF_SPL   = DEF_LINE_W / DEF_SAMPLE_W;
    localparam int DEF_LINES = DEF_SAMPLES / DEF_SPL;
    localparam int DEF_AW    = $clog2(DEF_SAMPLES);
    localparam int DEF_LW    = (DEF_LINES > 1) ? $clog2(DEF_LINES) : 1;

    // Reverse the low 'width' bits of idx; bits above width come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) r[width-1-i] = idx[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// One frame bank: single sample-wide write port, SPL-sample combinational line read.
// Latency: write visible next cycle, read is same-cycle; no backpressure (parent arbitrates).
module fft_bank_ram #(
    parameter int SAMPLE_W = 16,
    parameter int SAMPLES  = 2048,
    parameter int SPL      = 32,
    parameter int AW       = 11,
    parameter int LW       = 6
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [AW-1:0]           i_waddr,
    input  logic [SAMPLE_W-1:0]     i_wdata,
    input  logic [LW-1:0]           i_rline,
    output logic [SPL*SAMPLE_W-1:0] o_line
);

    logic [SAMPLE_W-1:0] r_mem [SAMPLES];

    // Payload storage carries no reset; validity lives in the parent's full flags.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    for (genvar k = 0; k < SPL; k++) begin : g_lane
        logic [AW-1:0] w_raddr;
        assign w_raddr = AW'(i_rline) * AW'(SPL) + AW'(k);
        assign o_line[k*SAMPLE_W +: SAMPLE_W] = r_mem[w_raddr];
    end

endmodule

// File: rtl/fft_output_pingpong.sv
// Ping-pong FFT result packer: fills one bank with a frame while the other drains as wide lines.
// Latency: first line valid 1 clk after last sample; backpressure: in_ready drops with both banks full, out side holds.
module fft_output_pingpong
    import fft_out_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int SAMPLES  = DEF_SAMPLES,
    parameter int LINE_W   = DEF_LINE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                bitrev_en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LINE_W-1:0]   out_data,
    output logic                out_last,
    output logic                out_bitrev,
    output logic [15:0]         frames_out
);

    localparam int SPL   = LINE_W / SAMPLE_W;
    localparam int LINES = SAMPLES / SPL;
    localparam int AW    = $clog2(SAMPLES);
    localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1;

    logic          r_wr_bank, r_rd_bank;
    logic [1:0]    r_full, r_bitrev_lat;
    logic [AW-1:0] r_wr_cnt;
    logic [LW-1:0] r_rd_line;
    logic [15:0]   r_frames_out;

    logic          w_wr_bank_nxt, w_rd_bank_nxt;
    logic [1:0]    w_full_nxt, w_bitrev_lat_nxt;
    logic [AW-1:0] w_wr_cnt_nxt;
    logic [LW-1:0] w_rd_line_nxt;
    logic [15:0]   w_frames_out_nxt;

    logic          w_wr_acc, w_wr_last, w_rd_acc, w_rd_last, w_lat_cur;
    logic [AW-1:0] w_waddr;
    logic          w_we0, w_we1;
    logic [LINE_W-1:0] w_line0, w_line1;

    assign in_ready  = !r_full[r_wr_bank];
    assign out_valid = r_full[r_rd_bank];

    assign w_wr_acc  = in_valid && in_ready && !flush;
    assign w_wr_last = (r_wr_cnt == AW'(SAMPLES - 1));
    assign w_rd_acc  = out_valid && out_ready && !flush;
    assign w_rd_last = (r_rd_line == LW'(LINES - 1));

    // The first sample of a frame uses bitrev_en directly since the latch loads on that same edge.
    assign w_lat_cur = (r_wr_cnt == '0) ? bitrev_en : r_bitrev_lat[r_wr_bank];
    assign w_waddr   = w_lat_cur ? AW'(bitrev(32'(r_wr_cnt), AW)) : r_wr_cnt;
    assign w_we0     = w_wr_acc && !r_wr_bank;
    assign w_we1     = w_wr_acc &&  r_wr_bank;

    fft_bank_ram #(
        .SAMPLE_W (SAMPLE_W),
        .SAMPLES  (SAMPLES),
        .SPL      (SPL),
        .AW       (AW),
        .LW       (LW)
    ) u_bank0 (
        .clk      (clk),
        .i_we     (w_we0),
        .i_waddr  (w_waddr),
        .i_wdata  (in_data),
        .i_rline  (r_rd_line),
        .o_line   (w_line0)
    );

    fft_bank_ram #(
        .SAMPLE_W (SAMPLE_W),
        .SAMPLES  (SAMPLES),
        .SPL      (SPL),
        .AW       (AW),
        .LW       (LW)
    ) u_bank1 (
        .clk      (clk),
        .i_we     (w_we1),
        .i_waddr  (w_waddr),
        .i_wdata  (in_data),
        .i_rline  (r_rd_line),
        .o_line   (w_line1)
    );

    assign out_data   = r_rd_bank ? w_line1 : w_line0;
    assign out_last   = out_valid && w_rd_last;
    assign out_bitrev = r_bitrev_lat[r_rd_bank];
    assign frames_out = r_frames_out;

    always_comb begin
        w_wr_bank_nxt    = r_wr_bank;
        w_rd_bank_nxt    = r_rd_bank;
        w_full_nxt       = r_full;
        w_bitrev_lat_nxt = r_bitrev_lat;
        w_wr_cnt_nxt     = r_wr_cnt;
        w_rd_line_nxt    = r_rd_line;
        w_frames_out_nxt = r_frames_out;
        if (flush) begin
            w_wr_bank_nxt    = 1'b0;
            w_rd_bank_nxt    = 1'b0;
            w_full_nxt       = '0;
            w_bitrev_lat_nxt = '0;
            w_wr_cnt_nxt     = '0;
            w_rd_line_nxt    = '0;
            w_frames_out_nxt = '0;
        end else begin
            // Write and read completions always address different banks, so both may land together.
            if (w_wr_acc) begin
                if (r_wr_cnt == '0) w_bitrev_lat_nxt[r_wr_bank] = bitrev_en;
                if (w_wr_last) begin
                    w_wr_cnt_nxt           = '0;
                    w_full_nxt[r_wr_bank]  = 1'b1;
                    w_wr_bank_nxt          = !r_wr_bank;
                end else begin
                    w_wr_cnt_nxt = r_wr_cnt + AW'(1);
                end
            end
            if (w_rd_acc) begin
                if (w_rd_last) begin
                    w_rd_line_nxt          = '0;
                    w_full_nxt[r_rd_bank]  = 1'b0;
                    w_rd_bank_nxt          = !r_rd_bank;
                    w_frames_out_nxt       = r_frames_out + 16'd1;
                end else begin
                    w_rd_line_nxt = r_rd_line + LW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_full       <= '0;
            r_bitrev_lat <= '0;
            r_wr_cnt     <= '0;
            r_rd_line    <= '0;
            r_frames_out <= '0;
        end else begin
            r_wr_bank    <= w_wr_bank_nxt;
            r_rd_bank    <= w_rd_bank_nxt;
            r_full       <= w_full_nxt;
            r_bitrev_lat <= w_bitrev_lat_nxt;
            r_wr_cnt     <= w_wr_cnt_nxt;
            r_rd_line    <= w_rd_line_nxt;
            r_frames_out <= w_frames_out_nxt;
        end
    end

endmodule
